// File: rtl/lstm_pkg.sv
// ---------------------------------------------------------------------------
// lstm_pkg
// Shared definitions for the LSTM weight-BRAM scheduler slice: burst mode
// encodings, scheduler state encoding and the default BRAM geometry and
// burst windows used by lstm_wbram_sched and its FIFO.
// ---------------------------------------------------------------------------
package lstm_pkg;

    // Mode encodings carried on iMode when a burst is started
    localparam logic SYS_type = 1'b0;
    localparam logic BR_type  = 1'b1;

    // Default BRAM geometry
    localparam int DEF_ADDR_W     = 11;
    localparam int DEF_DATA_W     = 256;
    localparam int DEF_FIFO_DEPTH = 4;

    // Default burst windows inside the weight BRAM
    localparam logic [DEF_ADDR_W-1:0] DEF_SYS_BASE = 11'h000;
    localparam int                    DEF_SYS_LEN  = 16;
    localparam logic [DEF_ADDR_W-1:0] DEF_BR_BASE  = 11'h400;
    localparam int                    DEF_BR_LEN   = 1024;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/lstm_wbram_fifo.sv
// ---------------------------------------------------------------------------
// lstm_wbram_fifo
// Small synchronous FIFO that buffers BRAM read words (plus their last flag)
// between the scheduler and the compute core. All storage and pointers are
// registers cleared by reset, so the head word is 0 after reset.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   i_flush       discard all entries (wins over push and pop)
//   i_push        write i_din at the tail
//   i_din         entry to write (WIDTH bits)
//   i_pop         remove the head entry
//   o_dout        head entry (registered storage)
//   o_empty       no entries held
//   o_count       number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module lstm_wbram_fifo
    import lstm_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    // Guard push/pop against full/empty so the pointers can never wrap past
    // each other even if a caller misbehaves.
    always_comb begin
        w_doPush = i_push && (r_count != CNT_W'(DEPTH));
        w_doPop  = i_pop  && (r_count != '0);
    end

    // Storage array; cleared on reset so the exposed head is 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_doPush && !i_flush) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    // Pointers and occupancy; flush returns to the empty state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rdPtr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/lstm_wbram_sched.sv
// ---------------------------------------------------------------------------
// lstm_wbram_sched
// Arbiter/scheduler for the single-port 256-bit LSTM weight BRAM. In IDLE the
// host owns the port and writes weights. A start request launches a SYSTEM or
// BRANCH read burst; reads are issued only while the output FIFO has credit,
// so the consumer may stall freely. oDone pulses the cycle after the last
// word is handed over; iAbort cancels a burst without oDone.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   iWr_valid/oWr_ready          host write handshake (ready only in IDLE)
//   iWr_addr, iWr_data           host write address and data
//   iStart, iMode                burst start (IDLE only), 0=SYSTEM 1=BRANCH
//   iAbort                       cancel an active burst
//   oBusy, oDone                 not-IDLE flag, end-of-burst pulse
//   oW_valid/iW_ready            weight stream handshake
//   oW_data, oW_last             weight word, final-word flag
//   oBram_en/we/addr/wdata       BRAM port controls
//   iBram_rdata                  BRAM read data (one cycle after enable)
// ---------------------------------------------------------------------------
module lstm_wbram_sched
    import lstm_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] SYS_BASE   = DEF_SYS_BASE,
    parameter int                SYS_LEN    = DEF_SYS_LEN,
    parameter logic [ADDR_W-1:0] BR_BASE    = DEF_BR_BASE,
    parameter int                BR_LEN     = DEF_BR_LEN,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iWr_valid,
    output logic              oWr_ready,
    input  logic [ADDR_W-1:0] iWr_addr,
    input  logic [DATA_W-1:0] iWr_data,
    input  logic              iStart,
    input  logic              iMode,
    input  logic              iAbort,
    output logic              oBusy,
    output logic              oDone,
    output logic              oW_valid,
    output logic [DATA_W-1:0] oW_data,
    output logic              oW_last,
    input  logic              iW_ready,
    output logic              oBram_en,
    output logic              oBram_we,
    output logic [ADDR_W-1:0] oBram_addr,
    output logic [DATA_W-1:0] oBram_wdata,
    input  logic [DATA_W-1:0] iBram_rdata
);

    localparam int IDX_W = $clog2(BR_LEN) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_len;
    logic [IDX_W-1:0]  r_idx;
    logic              r_inflight;
    logic              r_inflightLast;
    logic              r_done;
    logic              r_live;

    logic              w_wrReady;
    logic              w_issue;
    logic              w_issueLast;
    logic              w_credit;
    logic              w_flush;
    logic              w_finish;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [CNT_W:0]    w_used;
    logic [CNT_W-1:0]  w_fifoCount;
    logic [DATA_W:0]   w_fifoDout;

    // The host port is only offered in IDLE. r_live keeps it low while reset
    // is asserted so every output reads 0 during reset.
    assign w_wrReady = (r_state == IDLE) && r_live;

    // Credit: a read already in flight will land in the FIFO next edge, so it
    // counts against the free space before another read may be issued.
    always_comb begin
        w_used      = {1'b0, w_fifoCount} + {{CNT_W{1'b0}}, r_inflight};
        w_credit    = (w_used < (CNT_W + 1)'(FIFO_DEPTH));
        w_issueLast = (r_idx == (r_len - IDX_W'(1)));
    end

    // Next-state and burst control. Abort wins over everything and flushes
    // the FIFO; the completion of DRAIN is the handshake of the word that
    // carries the last flag, after which nothing else can be queued.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (iStart) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (iAbort) begin
                    w_nextState = IDLE;
                    w_flush     = 1'b1;
                end else if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_issueLast) begin
                        w_nextState = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (iAbort) begin
                    w_nextState = IDLE;
                    w_flush     = 1'b1;
                end else if (w_pop && w_fifoDout[DATA_W]) begin
                    w_nextState = IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Burst bookkeeping: window latched at start, index advanced per issued
    // read, and a one-cycle record of the read whose data arrives next.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base         <= '0;
            r_len          <= '0;
            r_idx          <= '0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
            r_done         <= 1'b0;
            r_live         <= 1'b0;
        end else begin
            r_live         <= 1'b1;
            r_done         <= w_finish;
            r_inflight     <= w_issue;
            r_inflightLast <= w_issue && w_issueLast;
            if ((r_state == IDLE) && iStart) begin
                r_base <= (iMode == BR_type) ? BR_BASE : SYS_BASE;
                r_len  <= (iMode == BR_type) ? IDX_W'(BR_LEN) : IDX_W'(SYS_LEN);
                r_idx  <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // BRAM port: host writes in IDLE, burst reads in RUN, idle otherwise
    always_comb begin
        oBram_en    = 1'b0;
        oBram_we    = 1'b0;
        oBram_addr  = '0;
        oBram_wdata = '0;
        if (w_wrReady && iWr_valid) begin
            oBram_en    = 1'b1;
            oBram_we    = 1'b1;
            oBram_addr  = iWr_addr;
            oBram_wdata = iWr_data;
        end else if (w_issue) begin
            oBram_en   = 1'b1;
            oBram_addr = r_base + ADDR_W'(r_idx);
        end
    end

    // Read data is captured in the cycle it is valid; an abort drops it.
    assign w_push = r_inflight;
    assign w_pop  = !w_empty && iW_ready;

    lstm_wbram_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_din   ({r_inflightLast, iBram_rdata}),
        .i_pop   (w_pop),
        .o_dout  (w_fifoDout),
        .o_empty (w_empty),
        .o_count (w_fifoCount)
    );

    assign oWr_ready = w_wrReady;
    assign oBusy     = (r_state != IDLE);
    assign oDone     = r_done;
    assign oW_valid  = !w_empty;
    assign oW_data   = w_fifoDout[DATA_W-1:0];
    assign oW_last   = w_fifoDout[DATA_W] && !w_empty;

endmodule

// File: tb/tb_lstm_wbram_sched.sv
// ---------------------------------------------------------------------------
// tb_lstm_wbram_sched
// Self-checking bench for lstm_wbram_sched with a behavioural BRAM model.
// Bursts push their expected words into a queue when started; a monitor
// process pops and compares on every weight handshake.
// ---------------------------------------------------------------------------
module tb_lstm_wbram_sched;
    import lstm_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 256;
    localparam logic [ADDR_W-1:0] SYS_BASE = 11'h000;
    localparam int SYS_LEN = 16;
    localparam logic [ADDR_W-1:0] BR_BASE = 11'h400;
    localparam int BR_LEN = 1024;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } expWord_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              iWr_valid = 1'b0;
    logic              oWr_ready;
    logic [ADDR_W-1:0] iWr_addr = '0;
    logic [DATA_W-1:0] iWr_data = '0;
    logic              iStart = 1'b0;
    logic              iMode = 1'b0;
    logic              iAbort = 1'b0;
    logic              oBusy;
    logic              oDone;
    logic              oW_valid;
    logic [DATA_W-1:0] oW_data;
    logic              oW_last;
    logic              iW_ready = 1'b1;
    logic              oBram_en;
    logic              oBram_we;
    logic [ADDR_W-1:0] oBram_addr;
    logic [DATA_W-1:0] oBram_wdata;
    logic [DATA_W-1:0] iBram_rdata;

    logic [DATA_W-1:0] bramMem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] refMem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] bramRdata;

    expWord_t expQ [$];
    expWord_t monWord;

    int  testsRun = 0;
    int  testsFailed = 0;
    int  cyc = 0;
    int  wordsSeen = 0;
    int  doneCount = 0;
    int  startCyc = 0;
    int  firstHsCyc = -1;
    int  lastHsCyc = -1;
    int  doneCyc = -1;
    int  maxCount = 0;
    bit  prevLastHs = 1'b0;
    bit  randomReady = 1'b0;

    lstm_wbram_sched #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SYS_BASE   (SYS_BASE),
        .SYS_LEN    (SYS_LEN),
        .BR_BASE    (BR_BASE),
        .BR_LEN     (BR_LEN),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iWr_valid   (iWr_valid),
        .oWr_ready   (oWr_ready),
        .iWr_addr    (iWr_addr),
        .iWr_data    (iWr_data),
        .iStart      (iStart),
        .iMode       (iMode),
        .iAbort      (iAbort),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oW_valid    (oW_valid),
        .oW_data     (oW_data),
        .oW_last     (oW_last),
        .iW_ready    (iW_ready),
        .oBram_en    (oBram_en),
        .oBram_we    (oBram_we),
        .oBram_addr  (oBram_addr),
        .oBram_wdata (oBram_wdata),
        .iBram_rdata (iBram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port BRAM model with one cycle of read latency
    always @(posedge clk) begin
        if (oBram_en) begin
            if (oBram_we) begin
                bramMem[oBram_addr] <= oBram_wdata;
            end else begin
                bramRdata <= bramMem[oBram_addr];
            end
        end
    end
    assign iBram_rdata = bramRdata;

    // Consumer readiness: always ready, or a coin flip each cycle
    always @(posedge clk) begin
        #1;
        iW_ready = randomReady ? 1'($urandom % 2) : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks oDone lands
    // exactly one cycle after the last-word handshake.
    always @(negedge clk) begin
        if (resetn) begin
            if (int'(dut.w_fifoCount) > maxCount) maxCount = int'(dut.w_fifoCount);
            if (oDone) begin
                doneCount++;
                doneCyc = cyc;
                checkOutput("done_after_last", DATA_W'(prevLastHs), 1);
            end else if (prevLastHs) begin
                checkOutput("done_after_last", DATA_W'(oDone), 1);
            end
            prevLastHs = 1'b0;
            if (oW_valid && iW_ready) begin
                if (firstHsCyc < 0) firstHsCyc = cyc;
                if (oW_last) lastHsCyc = cyc;
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_word: got %0h, expected no word", oW_data);
                end else begin
                    monWord = expQ.pop_front();
                    checkOutput($sformatf("word%0d_data", wordsSeen), oW_data, monWord.data);
                    checkOutput($sformatf("word%0d_last", wordsSeen), DATA_W'(oW_last),
                                DATA_W'(monWord.last));
                end
                wordsSeen++;
                prevLastHs = oW_last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wrValid, input logic [ADDR_W-1:0] wrAddr,
                                 input logic [DATA_W-1:0] wrData, input logic start,
                                 input logic mode, input logic abort);
        iWr_valid = wrValid;
        iWr_addr  = wrAddr;
        iWr_data  = wrData;
        iStart    = start;
        iMode     = mode;
        iAbort    = abort;
    endtask

    task automatic hostWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        applyStimulus(1'b1, a, d, 1'b0, 1'b0, 1'b0);
        refMem[a] = d;
        tick();
    endtask

    // Queue the expected words for a burst, then pulse iStart for one cycle
    task automatic startBurst(input logic mode);
        int base;
        int len;
        expWord_t e;
        base = (mode == BR_type) ? int'(BR_BASE) : int'(SYS_BASE);
        len  = (mode == BR_type) ? BR_LEN : SYS_LEN;
        for (int k = 0; k < len; k++) begin
            e.data = refMem[ADDR_W'(base + k)];
            e.last = (k == len - 1);
            expQ.push_back(e);
        end
        startCyc   = cyc;
        firstHsCyc = -1;
        lastHsCyc  = -1;
        doneCyc    = -1;
        iStart = 1'b1;
        iMode  = mode;
        tick();
        iStart = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int d0;
        d0 = doneCount;
        for (int i = 0; i < budget; i++) begin
            if (doneCount != d0) break;
            tick();
        end
        checkOutput(name, DATA_W'(doneCount - d0), 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int w0;
        int viol;

        // Reset values while reset is held
        #3;
        checkOutput("rst_busy", DATA_W'(oBusy), 0);
        checkOutput("rst_done", DATA_W'(oDone), 0);
        checkOutput("rst_wvalid", DATA_W'(oW_valid), 0);
        checkOutput("rst_bram_en", DATA_W'(oBram_en), 0);
        checkOutput("rst_wr_ready", DATA_W'(oWr_ready), 0);
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("post_rst_wr_ready", DATA_W'(oWr_ready), 1);

        // Host writes: the port follows the request combinationally
        applyStimulus(1'b1, 11'h000, 256'h0, 1'b0, SYS_type, 1'b0);
        #1;
        checkOutput("wr_bram_en", DATA_W'(oBram_en), 1);
        checkOutput("wr_bram_we", DATA_W'(oBram_we), 1);
        checkOutput("wr_bram_addr", DATA_W'(oBram_addr), 0);
        for (int a = 0; a < 16; a++) hostWrite(ADDR_W'(a), DATA_W'(a));
        for (int a = 'h400; a < 'h800; a++) hostWrite(ADDR_W'(a), DATA_W'(a));
        applyStimulus(1'b0, '0, '0, 1'b0, SYS_type, 1'b0);
        tick();

        // SYSTEM burst with the consumer always ready
        startBurst(SYS_type);
        checkOutput("sys_busy_t1", DATA_W'(oBusy), 1);
        checkOutput("sys_first_addr", DATA_W'(oBram_addr), DATA_W'(SYS_BASE));
        checkOutput("sys_first_read", DATA_W'({oBram_en, oBram_we}), 2'b10);
        waitDone(100, "sys_done_seen");
        checkOutput("sys_first_word_cyc", DATA_W'(firstHsCyc - startCyc), 3);
        checkOutput("sys_last_word_cyc", DATA_W'(lastHsCyc - startCyc), 18);
        checkOutput("sys_done_cyc", DATA_W'(doneCyc - startCyc), 19);
        checkOutput("sys_queue_empty", DATA_W'(expQ.size()), 0);

        // BRANCH burst under random backpressure
        tick();
        randomReady = 1'b1;
        w0 = wordsSeen;
        maxCount = 0;
        startBurst(BR_type);
        checkOutput("br_first_addr", DATA_W'(oBram_addr), DATA_W'(BR_BASE));
        waitDone(8000, "br_done_seen");
        randomReady = 1'b0;
        checkOutput("br_word_count", DATA_W'(wordsSeen - w0), BR_LEN);
        checkOutput("br_queue_empty", DATA_W'(expQ.size()), 0);
        checkOutput("br_fifo_credit", DATA_W'(maxCount <= 4), 1);
        tick();

        // Simultaneous host write and start, then a write held through the burst
        refMem[5] = 256'hA5;
        applyStimulus(1'b1, 11'h005, 256'hA5, 1'b0, SYS_type, 1'b0);
        startBurst(SYS_type);
        applyStimulus(1'b1, 11'h020, 256'h20, 1'b0, SYS_type, 1'b0);
        refMem[11'h020] = 256'h20;
        checkOutput("stall_wr_ready", DATA_W'(oWr_ready), 0);
        checkOutput("stall_bram_we", DATA_W'(oBram_we), 0);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (oDone) break;
            if (oWr_ready) viol++;
            tick();
        end
        checkOutput("stall_done_seen", DATA_W'(oDone), 1);
        checkOutput("stall_no_early_ready", DATA_W'(viol), 0);
        checkOutput("stall_ready_after_done", DATA_W'(oWr_ready), 1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, SYS_type, 1'b0);
        tick();
        checkOutput("stalled_write_landed", bramMem[11'h020], 256'h20);
        checkOutput("sim_queue_empty", DATA_W'(expQ.size()), 0);

        // Ignored inputs: iAbort in IDLE, iStart during RUN
        applyStimulus(1'b0, '0, '0, 1'b0, SYS_type, 1'b1);
        tick();
        iAbort = 1'b0;
        checkOutput("idle_abort_busy", DATA_W'(oBusy), 0);
        checkOutput("idle_abort_wr_ready", DATA_W'(oWr_ready), 1);
        d0 = doneCount;
        w0 = wordsSeen;
        startBurst(SYS_type);
        for (int i = 0; i < 3; i++) tick();
        iStart = 1'b1;
        iMode  = BR_type;
        tick();
        iStart = 1'b0;
        iMode  = SYS_type;
        waitDone(100, "ign_done_seen");
        for (int i = 0; i < 5; i++) tick();
        checkOutput("ign_word_count", DATA_W'(wordsSeen - w0), SYS_LEN);
        checkOutput("ign_done_count", DATA_W'(doneCount - d0), 1);
        checkOutput("ign_busy", DATA_W'(oBusy), 0);

        // Abort a BRANCH burst after 300 words
        randomReady = 1'b1;
        w0 = wordsSeen;
        d0 = doneCount;
        startBurst(BR_type);
        for (int i = 0; i < 3000; i++) begin
            if (wordsSeen - w0 >= 300) break;
            tick();
        end
        checkOutput("abort_reached_300", DATA_W'(wordsSeen - w0 >= 300), 1);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        randomReady = 1'b0;
        expQ.delete();
        checkOutput("abort_busy", DATA_W'(oBusy), 0);
        checkOutput("abort_wvalid", DATA_W'(oW_valid), 0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("abort_no_done", DATA_W'(doneCount - d0), 0);
        w0 = wordsSeen;
        startBurst(SYS_type);
        waitDone(100, "post_abort_done_seen");
        checkOutput("post_abort_words", DATA_W'(wordsSeen - w0), SYS_LEN);
        checkOutput("post_abort_queue", DATA_W'(expQ.size()), 0);

        // Asynchronous reset in the middle of a burst
        tick();
        startBurst(SYS_type);
        for (int i = 0; i < 5; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_rst_busy", DATA_W'(oBusy), 0);
        checkOutput("async_rst_done", DATA_W'(oDone), 0);
        checkOutput("async_rst_wvalid", DATA_W'(oW_valid), 0);
        checkOutput("async_rst_bram_en", DATA_W'(oBram_en), 0);
        checkOutput("async_rst_wr_ready", DATA_W'(oWr_ready), 0);
        expQ.delete();
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("async_post_wr_ready", DATA_W'(oWr_ready), 1);
        w0 = wordsSeen;
        startBurst(SYS_type);
        waitDone(100, "after_rst_done_seen");
        checkOutput("after_rst_words", DATA_W'(wordsSeen - w0), SYS_LEN);
        checkOutput("after_rst_queue", DATA_W'(expQ.size()), 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
